// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view: it consumes the byte stream and drives
// the memory write strobe, address and data. The host/harness side uses master.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Frame: count[7:0], count[15:8], count little-endian 32-bit words, XOR checksum.
// Each assembled word is written once; the CPU stays held in reset until the
// whole image is written and the checksum byte matches.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = '0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic          clock,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    input  logic          restart,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic        ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  count_lo;
    logic [15:0] count_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] count_full;

    assign accept     = bus.in_valid && ready_q;
    assign count_full = {bus.in_data, count_lo};

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Frame parser, word assembler and write/status register updates.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            count_lo <= '0;
            count_q  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            csum     <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        count_lo <= bus.in_data;
                        csum     <= bus.in_data;
                        state    <= S_CNT_HI;
                    end else begin
                        csum     <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end

                S_CNT_HI: begin
                    if (accept) begin
                        count_q <= count_full;
                        csum    <= csum ^ bus.in_data;
                        if (32'(count_full) > MAX_W) begin
                            error   <= 1'b1;
                            ready_q <= 1'b0;
                            state   <= S_ERROR;
                        end else if (count_full == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    // ready_q low here means this is the write stall cycle.
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        csum     <= csum ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_q     <= 1'b1;
                            wdata_q  <= {bus.in_data, shift_q};
                            addr_q   <= BASE_ADDR + 32'(word_idx);
                            ready_q  <= 1'b0;
                            word_idx <= word_idx + 16'd1;
                            if (word_idx + 16'd1 == count_q) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            shift_q <= {bus.in_data, shift_q[23:8]};
                        end
                    end
                end

                S_CHECK: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        ready_q <= 1'b0;
                        if (bus.in_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    ready_q <= 1'b0;
                    if (restart) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    ready_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: instance A uses default parameters,
// instance B uses BASE_ADDR=0xFFFFFFFF and MAX_WORDS=4.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic [1:0] v;
    logic [7:0] d;
    logic       rs_a, rs_b;
    logic       hold_a, done_a, err_a;
    logic       hold_b, done_b, err_b;
    bit         mon_en;

    int checks;
    int errors;
    int rdy_bad;

    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    assign ifa.in_valid = v[0];
    assign ifb.in_valid = v[1];
    assign ifa.in_data  = d;
    assign ifb.in_data  = d;

    imem_loader dut_a (
        .clock    (clk),
        .rst_n    (rst_n),
        .bus      (ifa.slave),
        .restart  (rs_a),
        .cpu_hold (hold_a),
        .done     (done_a),
        .error    (err_a)
    );

    imem_loader #(
        .BASE_ADDR (32'hFFFF_FFFF),
        .MAX_WORDS (4)
    ) dut_b (
        .clock    (clk),
        .rst_n    (rst_n),
        .bus      (ifb.slave),
        .restart  (rs_b),
        .cpu_hold (hold_b),
        .done     (done_b),
        .error    (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write; while a frame is in flight in_ready must be !mem_we.
    always @(negedge clk) begin
        if (ifa.mem_we) wq_a.push_back({ifa.mem_addr, ifa.mem_wdata});
        if (ifb.mem_we) wq_b.push_back({ifb.mem_addr, ifb.mem_wdata});
        if (mon_en && rst_n) begin
            if (!done_a && !err_a && (ifa.in_ready === ifa.mem_we)) rdy_bad++;
            if (!done_b && !err_b && (ifb.in_ready === ifb.mem_we)) rdy_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 1) ? ifb.in_ready : ifa.in_ready;
    endfunction

    // Offer one byte (called at a negedge) and hold it until accepted.
    task automatic send_byte(input int sel, input logic [7:0] b, input bit rnd);
        bit got;
        if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
        d      = b;
        v[sel] = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            got = rdy(sel);
            @(posedge clk);
            @(negedge clk);
        end
        v = '0;
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] last, input bit rnd);
        logic [7:0] f [0:9];
        f = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'hFF, 8'hFF, 8'hFF, 8'hEA};
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(sel, f[i], rnd);
        send_byte(sel, last, rnd);
        @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic pulse_restart(input int sel);
        if (sel == 1) rs_b = 1'b1; else rs_a = 1'b1;
        @(negedge clk);
        rs_a = 1'b0;
        rs_b = 1'b0;
    endtask

    task automatic check_nominal_writes(input string tag);
        check({tag, "_nw"}, 64'(wq_a.size()), 64'd2);
        if (wq_a.size() == 2) begin
            check({tag, "_w0"}, wq_a[0], {32'h0000_0000, 32'hE3A0_0014});
            check({tag, "_w1"}, wq_a[1], {32'h0000_0001, 32'hEAFF_FFFF});
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rdy_bad = 0;
        mon_en  = 1'b0;
        v       = '0;
        d       = '0;
        rs_a    = 1'b0;
        rs_b    = 1'b0;
        rst_n   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready",  64'(ifa.in_ready),  64'd0);
        check("rst_we",     64'(ifa.mem_we),    64'd0);
        check("rst_addr_a", 64'(ifa.mem_addr),  64'h0);
        check("rst_addr_b", 64'(ifb.mem_addr),  64'hFFFF_FFFF);
        check("rst_wdata",  64'(ifa.mem_wdata), 64'h0);
        check("rst_hold",   64'(hold_a),        64'd1);
        check("rst_done",   64'(done_a),        64'd0);
        check("rst_err",    64'(err_a),         64'd0);
        rst_n = 1'b1;
        check("ready_before_edge", 64'(ifa.in_ready), 64'd0);
        @(negedge clk);
        check("ready_after_rst", 64'(ifa.in_ready), 64'd1);

        // Nominal 2-word image
        send_frame(0, 8'h40, 1'b0);
        check_nominal_writes("nom");
        check("nom_done",  64'(done_a),       64'd1);
        check("nom_hold",  64'(hold_a),       64'd0);
        check("nom_err",   64'(err_a),        64'd0);
        check("nom_ready", 64'(ifa.in_ready), 64'd0);
        check("nom_addr_hold", 64'(ifa.mem_addr), 64'h1);

        // Bad checksum
        pulse_restart(0);
        check("rst_hold_back", 64'(hold_a), 64'd1);
        wq_a.delete();
        send_frame(0, 8'h41, 1'b0);
        check_nominal_writes("bad");
        check("bad_err",  64'(err_a),  64'd1);
        check("bad_hold", 64'(hold_a), 64'd1);
        check("bad_done", 64'(done_a), 64'd0);
        repeat (3) @(negedge clk);
        check("bad_restart_ignored", 64'(err_a), 64'd1);
        pulse_restart(0);
        check("rec_ready", 64'(ifa.in_ready), 64'd1);
        check("rec_err",   64'(err_a),        64'd0);
        check("rec_hold",  64'(hold_a),       64'd1);

        // Count overflow on instance B (MAX_WORDS=4)
        send_byte(1, 8'h05, 1'b0);
        check("ovf_err_early", 64'(err_b), 64'd0);
        send_byte(1, 8'h00, 1'b0);
        check("ovf_err",   64'(err_b),        64'd1);
        check("ovf_ready", 64'(ifb.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("ovf_nowrite", 64'(wq_b.size()), 64'd0);
        pulse_restart(1);

        // Zero count
        wq_a.delete();
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        @(negedge clk);
        check("zero_done",    64'(done_a),      64'd1);
        check("zero_err",     64'(err_a),       64'd0);
        check("zero_nowrite", 64'(wq_a.size()), 64'd0);
        pulse_restart(0);

        // Backpressure: random gaps, valid held through the stall cycle
        wq_a.delete();
        send_frame(0, 8'h40, 1'b1);
        check_nominal_writes("bp");
        check("bp_done", 64'(done_a), 64'd1);
        check("bp_err",  64'(err_a),  64'd0);
        pulse_restart(0);

        // Reset mid-word
        wq_a.delete();
        mon_en = 1'b1;
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h14, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ifa.in_ready), 64'd0);
        check("midrst_hold",  64'(hold_a),       64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 8'h40, 1'b0);
        check_nominal_writes("midrst");
        check("midrst_done", 64'(done_a), 64'd1);

        // Base offset with wrap on instance B
        wq_b.delete();
        send_frame(1, 8'h40, 1'b0);
        check("base_nw", 64'(wq_b.size()), 64'd2);
        if (wq_b.size() == 2) begin
            check("base_w0", wq_b[0], {32'hFFFF_FFFF, 32'hE3A0_0014});
            check("base_w1", wq_b[1], {32'h0000_0000, 32'hEAFF_FFFF});
        end
        check("base_done", 64'(done_b), 64'd1);

        check("ready_vs_we", 64'(rdy_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's word-addressed instruction memory. Accepts a byte stream over a valid/ready handshake, frames it as a little-endian word count, instruction words, and an XOR checksum. Issues one 32-bit write per assembled word and holds the CPU in reset until the image is loaded and verified. Sits between the host link (UART/test harness) and the instruction memory write port.

## Interface

- BASE_ADDR, 0: word address of the first written instruction.
- MAX_WORDS, 1024: largest accepted word count; a larger count is a framing error.
- clock  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- restart  input  1  one-cycle pulse; returns the loader from DONE/ERROR to IDLE.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  word address for the write.
- mem_wdata  output  32  instruction word for the write.
- cpu_hold  output  1  holds the CPU in reset while high.
- done  output  1  image loaded, checksum matched.
- error  output  1  count overflow or checksum mismatch.

## Operation

- A byte is accepted only when in_valid && in_ready are both high on a rising edge. Bytes offered while in_ready=0 are ignored.
- States and transitions:
  - IDLE: first accepted byte is count[7:0], go to CNT_HI.
  - CNT_HI: accepted byte is count[15:8].
    - count > MAX_WORDS: go to ERROR.
    - count == 0: go to CHECK.
    - otherwise: go to DATA.
  - DATA: bytes are collected little-endian into a 32-bit shift register, tracked by a 2-bit byte counter.
    - On the 4th byte, the word is registered and written (see Timing). The word index increments.
    - When the word index reaches count, go to CHECK.
  - CHECK: accepted byte is compared with the running checksum.
    - Equal: go to DONE.
    - Not equal: go to ERROR.
  - DONE / ERROR: in_ready=0. A restart pulse clears the word index, byte counter, checksum and done/error, then goes to IDLE.
- Checksum: running XOR of every accepted byte from count[7:0] through the last data byte. It is cleared in IDLE.
- mem_addr = BASE_ADDR + word index, computed at 32-bit width with wrap-around.
- Words are written before the checksum is verified. On ERROR, cpu_hold stays high, so partially written memory is never executed.
- restart is ignored in IDLE, CNT_HI, DATA and CHECK.

## Timing

- Reset values:
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0.
  - State IDLE.
  - in_ready rises on the first clock after rst_n deasserts.
- in_ready is 1 in IDLE, CNT_HI, DATA and CHECK. It is 0 in DONE and ERROR, and for the single cycle in which mem_we is high, so that write and accept never overlap.
- Write latency: mem_we is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are valid and stable during that cycle and hold their values afterwards.
- done=1 and cpu_hold=0 the cycle after a matching checksum byte is accepted. Both hold until restart or reset.
- error=1 the cycle after the offending byte is accepted. It holds until restart or reset.
- Restart: cpu_hold reasserts in the cycle after the restart pulse.
- rst_n low mid-frame forces all reset values immediately (asynchronously). A partial word is discarded and never written.
- Throughput: one byte per cycle, except for the stall cycle per word.

## Test plan

- Nominal 2-word image:
  - Stimulus: bytes 02 00 14 00 A0 E3 FF FF FF EA 40.
  - Writes: mem_we pulses twice, (addr 0, 0xE3A00014) and (addr 1, 0xEAFFFFFF).
  - Result: done=1, cpu_hold=0, error=0, in_ready=0.
- Bad checksum:
  - Stimulus: same frame with last byte 41.
  - Result: both writes still occur; error=1, cpu_hold=1, done=0.
  - Recovery: a restart pulse returns to IDLE with in_ready=1.
- Overflow and zero count:
  - MAX_WORDS=4, bytes 05 00: error=1 after the 2nd byte, and mem_we never pulses.
  - Bytes 00 00 00: done=1 and no writes.
- Backpressure:
  - Stimulus: nominal frame with in_valid toggling randomly, held across the mem_we stall cycle.
  - Result: identical writes and done. No byte is lost or duplicated; in_ready=0 exactly on the write cycles.
- Reset mid-word:
  - Stimulus: assert rst_n low after bytes 02 00 14 00, then send the full nominal frame.
  - Result: no write with 0x????0014 precedes the frame; the result matches the nominal case.
- Base offset:
  - Stimulus: BASE_ADDR=0xFFFFFFFF with the nominal frame.
  - Result: writes go to 0xFFFFFFFF, then 0x00000000 (wrap).
